// File: rtl/group_max_forward.sv
// group_max_forward: accumulates the signed maximum over a row of tokens and writes
// it back onto that row's tokens while they travel through a DEPTH-stage delay line.
`timescale 1ns/1ps

module group_max_stage #(
  parameter int DW    = 16,
  parameter int PW    = 16,
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_fwd,
  input  logic [DW-1:0]    i_front,
  input  logic             i_vld,
  input  logic [DW-1:0]    i_max,
  input  logic [LEN_W-1:0] i_len,
  input  logic [PW-1:0]    i_data,
  input  logic             i_first,
  input  logic             i_last,
  input  logic             i_pend,
  output logic             o_vld,
  output logic [DW-1:0]    o_max,
  output logic [LEN_W-1:0] o_len,
  output logic [PW-1:0]    o_data,
  output logic             o_first,
  output logic             o_last,
  output logic             o_pend
);
  localparam logic [DW-1:0] MIN = {1'b1, {(DW-1){1'b0}}};

  // A token still waiting for its row max picks it up the cycle the row closes.
  logic hit;
  assign hit = i_fwd & i_vld & i_pend;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vld   <= 1'b0;
      o_max   <= MIN;
      o_len   <= '0;
      o_data  <= '0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
      o_pend  <= 1'b0;
    end else if (i_en) begin
      o_vld   <= i_vld;
      o_len   <= i_len;
      o_data  <= i_data;
      o_first <= i_first;
      o_last  <= i_last;
      o_max   <= hit ? i_front : i_max;
      o_pend  <= hit ? 1'b0 : i_pend;
    end
  end
endmodule

module group_max_forward #(
  parameter int DW    = 16,
  parameter int PW    = 16,
  parameter int DEPTH = 12,
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [DW-1:0]    i_loc_max,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_last,
  input  logic [PW-1:0]    i_data,
  input  logic             i_err_clr,
  output logic             o_valid,
  output logic [DW-1:0]    o_max,
  output logic [LEN_W-1:0] o_len,
  output logic [PW-1:0]    o_data,
  output logic             o_first,
  output logic             o_last,
  output logic             o_err
);
  localparam logic [DW-1:0] MIN = {1'b1, {(DW-1){1'b0}}};

  // Index 0 is the token being presented; index k+1 is the output of stage k.
  logic [DEPTH:0]            vld_pipe, first_pipe, last_pipe, pend_pipe;
  logic [DEPTH:0][DW-1:0]    max_pipe;
  logic [DEPTH:0][LEN_W-1:0] len_pipe;
  logic [DEPTH:0][PW-1:0]    data_pipe;

  logic [DW-1:0]    acc, front;
  logic [LEN_W-1:0] cnt, len_q, leff;
  logic             row_open, accept, close, close_acc;
  logic [31:0]      len_raw, leff32;

  always_comb begin
    len_raw = 32'(row_open ? len_q : i_len);
    if (len_raw == 32'd0)               leff32 = 32'd1;
    else if (len_raw > 32'(DEPTH))      leff32 = 32'(DEPTH);
    else                                leff32 = len_raw;
  end

  assign leff      = LEN_W'(leff32);
  assign accept    = i_en & i_valid;
  assign front     = ($signed(i_loc_max) > $signed(acc)) ? i_loc_max : acc;
  assign close     = i_last | ((32'(cnt) + 32'd1) == leff32);
  assign close_acc = accept & close;

  assign vld_pipe[0]   = i_valid;
  assign max_pipe[0]   = (i_valid & close) ? front : i_loc_max;
  assign len_pipe[0]   = leff;
  assign data_pipe[0]  = i_data;
  assign first_pipe[0] = i_valid & ~row_open;
  assign last_pipe[0]  = i_valid & close;
  assign pend_pipe[0]  = i_valid & ~close;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc      <= MIN;
      cnt      <= '0;
      row_open <= 1'b0;
      len_q    <= '0;
    end else if (accept) begin
      if (close) begin
        acc      <= MIN;
        cnt      <= '0;
        row_open <= 1'b0;
      end else begin
        acc      <= front;
        cnt      <= cnt + 1'b1;
        row_open <= 1'b1;
        if (!row_open) len_q <= leff;
      end
    end
  end

  // Stage 0 never forwards: its incoming token is pending only when the row stays open.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    group_max_stage #(.DW(DW), .PW(PW), .LEN_W(LEN_W)) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_en),
      .i_fwd   (close_acc),
      .i_front (front),
      .i_vld   (vld_pipe[k]),
      .i_max   (max_pipe[k]),
      .i_len   (len_pipe[k]),
      .i_data  (data_pipe[k]),
      .i_first (first_pipe[k]),
      .i_last  (last_pipe[k]),
      .i_pend  (pend_pipe[k]),
      .o_vld   (vld_pipe[k+1]),
      .o_max   (max_pipe[k+1]),
      .o_len   (len_pipe[k+1]),
      .o_data  (data_pipe[k+1]),
      .o_first (first_pipe[k+1]),
      .o_last  (last_pipe[k+1]),
      .o_pend  (pend_pipe[k+1])
    );
  end

  // A token leaving while still pending means its row spanned more than the line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                     o_err <= 1'b0;
    else if (i_en) begin
      if (vld_pipe[DEPTH] & pend_pipe[DEPTH])      o_err <= 1'b1;
      else if (i_err_clr)                          o_err <= 1'b0;
    end
  end

  assign o_valid = vld_pipe[DEPTH];
  assign o_max   = max_pipe[DEPTH];
  assign o_len   = len_pipe[DEPTH];
  assign o_data  = data_pipe[DEPTH];
  assign o_first = first_pipe[DEPTH];
  assign o_last  = last_pipe[DEPTH];
endmodule

// File: tb/tb_group_max_forward.sv
// Bench for group_max_forward: scenarios are segmented into rows by a reference model
// and every output cycle is compared against the expected token of that cycle.
`timescale 1ns/1ps

module tb_group_max_forward;
  localparam int DW = 16, PW = 16, DEPTH = 12, LEN_W = 4, MAXS = 80;
  localparam logic signed [DW-1:0] MINV = 16'sh8000;

  logic i_clk = 1'b0;
  logic i_rst, i_en, i_valid, i_last, i_err_clr;
  logic signed [DW-1:0] i_loc_max;
  logic [LEN_W-1:0] i_len;
  logic [PW-1:0] i_data;
  logic o_valid, o_first, o_last, o_err;
  logic signed [DW-1:0] o_max;
  logic [LEN_W-1:0] o_len;
  logic [PW-1:0] o_data;

  group_max_forward #(.DW(DW), .PW(PW), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid),
    .i_loc_max(i_loc_max), .i_len(i_len), .i_last(i_last), .i_data(i_data),
    .i_err_clr(i_err_clr), .o_valid(o_valid), .o_max(o_max), .o_len(o_len),
    .o_data(o_data), .o_first(o_first), .o_last(o_last), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // scenario: one entry per enabled cycle
  logic                 s_v[MAXS], s_last[MAXS], s_clr[MAXS];
  logic signed [DW-1:0] s_m[MAXS];
  logic [LEN_W-1:0]     s_len[MAXS];
  logic [PW-1:0]        s_d[MAXS];
  int                   ns;
  // expectations
  logic signed [DW-1:0] e_max[MAXS];
  logic [LEN_W-1:0]     e_len[MAXS];
  logic                 e_first[MAXS], e_last[MAXS], e_ov[MAXS];
  logic                 err_m;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_sc();
    ns = 0;
  endtask

  task automatic push(input logic v, input int m, input int len, input logic last,
                      input logic clr = 1'b0);
    if (ns < MAXS) begin
      s_v[ns] = v; s_m[ns] = 16'(m); s_len[ns] = LEN_W'(len);
      s_last[ns] = last; s_clr[ns] = clr; s_d[ns] = 16'($urandom);
      ns++;
    end
  endtask

  task automatic bubble();
    push(1'b0, int'($urandom), int'($urandom_range(15)), 1'($urandom));
  endtask

  // Split accepted tokens into rows; a token overflows if its row closes DEPTH or
  // more cycles after it entered (or never closes).
  function automatic void compute();
    int members[$];
    logic open = 1'b0;
    int leff = 1;
    logic signed [DW-1:0] rmax = MINV;
    for (int n = 0; n < ns; n++) begin
      e_first[n] = 0; e_last[n] = 0; e_ov[n] = 0; e_max[n] = s_m[n]; e_len[n] = '0;
      if (!s_v[n]) continue;
      if (!open) begin
        int lv = int'(s_len[n]);
        leff = (lv == 0) ? 1 : ((lv > DEPTH) ? DEPTH : lv);
        members.delete();
        rmax = s_m[n];
        open = 1;
        e_first[n] = 1;
      end else if (s_m[n] > rmax) rmax = s_m[n];
      members.push_back(n);
      e_len[n] = LEN_W'(leff);
      if (s_last[n] || members.size() == leff) begin
        foreach (members[j]) begin
          e_ov[members[j]]  = (n - members[j]) >= DEPTH;
          e_max[members[j]] = e_ov[members[j]] ? s_m[members[j]] : rmax;
        end
        e_last[n] = 1;
        open = 0;
      end
    end
    if (open) foreach (members[j]) e_ov[members[j]] = 1;
  endfunction

  // outputs after n_edges enabled edges show the token of step n_edges-DEPTH
  task automatic check_out(input int n_edges);
    int t = n_edges - DEPTH;
    chk("err", o_err, err_m);
    if (t < 0) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_max", o_max, MINV);
      chk("rst_data", o_data, 0);
      chk("rst_flags", {o_first, o_last}, 0);
    end else if (t >= ns || !s_v[t]) begin
      chk("bubble_valid", o_valid, 0);
    end else begin
      chk("valid", o_valid, 1);
      chk("max", o_max, e_max[t]);
      chk("data", o_data, s_d[t]);
      chk("len", o_len, e_len[t]);
      chk("first", o_first, e_first[t]);
      chk("last", o_last, e_last[t]);
    end
  endtask

  task automatic garbage(input logic en);
    i_en = en; i_valid = 1'($urandom); i_loc_max = 16'($urandom);
    i_len = LEN_W'($urandom); i_last = 1'($urandom); i_data = 16'($urandom);
    i_err_clr = 1'($urandom);
  endtask

  task automatic reset_dut();
    garbage(1'b0);
    i_rst = 1'b1;
    @(negedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic stall_cycle(input int n_edges);
    garbage(1'b0);
    @(posedge i_clk); @(negedge i_clk);
    check_out(n_edges);
  endtask

  task automatic run(input bit do_reset, input int stall_pct, input int stall_at,
                     input int stall_n);
    compute();
    if (do_reset) reset_dut();
    err_m = 1'b0;
    check_out(0);
    for (int s = 0; s < ns + DEPTH + 1; s++) begin
      if (s == stall_at) for (int k = 0; k < stall_n; k++) stall_cycle(s);
      for (int k = 0; k < 2 && stall_pct > 0 && int'($urandom_range(99)) < stall_pct; k++)
        stall_cycle(s);
      if (s < ns) begin
        i_en = 1; i_valid = s_v[s]; i_loc_max = s_m[s]; i_len = s_len[s];
        i_last = s_last[s]; i_data = s_d[s]; i_err_clr = s_clr[s];
      end else begin
        garbage(1'b1); i_valid = 0; i_err_clr = 0;
      end
      @(posedge i_clk);
      if (s >= DEPTH && s - DEPTH < ns && s_v[s-DEPTH] && e_ov[s-DEPTH]) err_m = 1'b1;
      else if (s < ns && s_clr[s]) err_m = 1'b0;
      @(negedge i_clk);
      check_out(s + 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    garbage(1'b0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // contiguous L=4
    clr_sc();
    push(1, 5, 4, 0); push(1, -3, 4, 0); push(1, 9, 4, 0); push(1, 2, 4, 0);
    run(1, 0, -1, 0);

    // L=3 with bubbles
    clr_sc();
    push(1, -100, 3, 0); bubble(); push(1, -7, 3, 0); bubble(); bubble(); push(1, -50, 3, 0);
    run(1, 0, -1, 0);

    // early close then L=2 with a tie
    clr_sc();
    push(1, 1, 8, 0); push(1, 4, 8, 0); push(1, 2, 8, 1); push(1, 3, 2, 0); push(1, 3, 2, 0);
    run(1, 0, -1, 0);

    // L=12 spanning 12 cycles: first token overflows, then clear the flag
    clr_sc();
    push(1, -1000, 12, 0); bubble();
    for (int k = 0; k < 11; k++) push(1, int'($urandom_range(2000)) - 500, 12, 0);
    while (ns < 16) bubble();
    push(0, 0, 0, 0, 1'b1);
    run(1, 0, -1, 0);

    // L=6 plain and with a 3-cycle stall mid-row
    clr_sc();
    for (int k = 0; k < 6; k++) push(1, int'($urandom), 6, 0);
    run(1, 0, -1, 0);
    run(1, 0, 3, 3);

    // passthrough: L=1, L=0, last on first token
    clr_sc();
    for (int k = 0; k < 4; k++) push(1, int'($urandom), 1, 0);
    for (int k = 0; k < 4; k++) push(1, int'($urandom), 0, 0);
    for (int k = 0; k < 2; k++) push(1, int'($urandom), 7, 1);
    run(1, 0, -1, 0);

    // asynchronous reset mid-row
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      i_en = 1; i_valid = 1; i_loc_max = 16'($urandom); i_len = 4'd15;
      i_last = 0; i_data = 16'($urandom) | 16'd1; i_err_clr = 0;
      @(posedge i_clk); @(negedge i_clk);
    end
    chk("pre_rst_valid", o_valid, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_max", o_max, MINV);
    chk("arst_data", o_data, 0);
    chk("arst_err", o_err, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    clr_sc();
    push(1, 32'h7FFF, 2, 0); push(1, -32768, 2, 0);
    run(0, 0, -1, 0);

    // randomized rows with bubbles, early closes, stalls and error clears
    for (int r = 0; r < 6; r++) begin
      clr_sc();
      for (int s = 0; s < 60; s++)
        push(int'($urandom_range(99)) < 70, int'($urandom), int'($urandom_range(15)),
             int'($urandom_range(99)) < 8, int'($urandom_range(99)) < 4);
      run(1, 10, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/group_max_forward.md
# group_max_forward

Parametrised group-maximum forwarding pipeline for the softmax max-tree path. The block takes a stream of per-chunk local maxima with a payload, groups consecutive valid tokens into rows of programmable length, and accumulates the signed row maximum. It then back-annotates that maximum onto every token of the row while the tokens travel through a fixed-depth delay line. Every token leaves exactly DEPTH cycles after entry, carrying its row's global maximum. Unlike the earlier fixed 12-stage version, bubbles inside a row are tolerated, a row can be closed early, and a row span that exceeds the pipeline depth is flagged.

## Interface
- DW, 16: width of max values, signed two's complement.
- PW, 16: payload width, passed through untouched.
- DEPTH, 12: delay-line stages (≥2); also the maximum row span in cycles.
- LEN_W, 4: width of the row-length field.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_en  in  1  global enable; 0 freezes all state.
- i_valid  in  1  token present this cycle.
- i_loc_max  in  DW  signed local maximum of the token.
- i_len  in  LEN_W  row length L; sampled only on a row's first token.
- i_last  in  1  force this token to close the row.
- i_data  in  PW  payload.
- i_err_clr  in  1  clears o_err.
- o_valid  out  1  delayed i_valid.
- o_max  out  DW  global row maximum for the output token.
- o_len  out  LEN_W  latched L of the token's row.
- o_data  out  PW  delayed payload.
- o_first  out  1  token was first of its row.
- o_last  out  1  token closed its row.
- o_err  out  1  sticky span-overflow flag.

## Operation
- Delay line: DEPTH stages. Each stage holds valid, max, len, data, first, last and pend. The line shifts on every cycle with i_en=1, whether or not i_valid is set. Outputs come from stage DEPTH-1.
- Row state: acc (DW, reset value -2^(DW-1)), cnt (LEN_W), open (1), len_q (LEN_W).
- Effective length: Leff = i_len on the first token (open=0), otherwise len_q. A value of 0 is treated as 1. Values above DEPTH are clamped to DEPTH.
- On an accepted token (i_en & i_valid):
  - front = signed max(acc, i_loc_max); ties keep acc.
  - close = i_last OR (cnt+1 == Leff).
  - If not close: acc←front, cnt←cnt+1, open←1. If this is the first token, len_q←Leff. The token enters stage 0 with max=i_loc_max and pend=1.
  - If close: the token enters stage 0 with max=front and pend=0. In the same edge, every stage k≥1 whose incoming token (from stage k-1) is valid and pend=1 loads max=front and clears pend. Then acc←-2^(DW-1), cnt←0, open←0.
- Bubbles (i_valid=0): acc, cnt and open are held. An invalid token enters stage 0 with pend=0.
- Stage 0 first flag = !open; stage 0 last flag = close.
- Overflow: if stage DEPTH-1 holds a valid token with pend=1 (the row has not closed before its token exits), that token exits with o_max equal to its own local max. o_err is set at the next edge. Tokens of the row still in the line receive front when the row closes. o_err is cleared by i_err_clr (set wins on a simultaneous event) or by reset.
- L=1 (or i_last on the first token) is passthrough: o_max = own i_loc_max.

## Timing
- Latency: exactly DEPTH enabled cycles from input to output, for every token.
- A contiguous row of length L ≤ DEPTH never overflows. More generally, no overflow occurs when the cycle distance from first to last token is ≤ DEPTH-1.
- i_en=0: all registers hold, including acc, cnt and o_err; the inputs of that cycle are ignored.
- Reset (asynchronous, any time, including mid-row):
  - all stage valid/pend/first/last = 0, max = -2^(DW-1), data/len = 0;
  - acc = -2^(DW-1), cnt = 0, open = 0, o_err = 0.
  - The partial row is discarded; the first valid token after reset starts a new row.
- i_len changes mid-row are ignored (len_q is used).

## Test plan
- DW=16, DEPTH=12; L=4, contiguous inputs 5, -3, 9, 2 -> after 12 cycles, four consecutive outputs with o_max=9; o_first on token 1, o_last on token 4.
- L=3 with bubbles, valids at cycles 0, 2, 5 and values -100, -7, -50 -> outputs at cycles 12, 14, 17 all show o_max=-7 (0xFFF9); o_err stays 0.
- L=8 with i_last on the third token (values 1, 4, 2), then a new row with L=2 (values 3, 3) -> first row o_max=4 with o_last on token 3; second row o_max=3.
- L=12 with one bubble after the first token (span 12 cycles) -> token 1 exits with its own local max, o_err rises one cycle later, remaining tokens carry the row maximum; i_err_clr then drops o_err.
- Mid-row stalls and resets:
  - L=6, i_en low for 3 cycles mid-row -> results identical to the unstalled run, shifted by 3 cycles.
  - Asynchronous reset mid-row -> outputs go to zero/-32768 immediately; a new L=2 row (0x7FFF, 0x8000) gives o_max=0x7FFF.
- L=1 and L=0 -> every output o_max equals its input, o_first=o_last=1.
